hazard_ctrl_unit: RTL and testbench
===================================

Name: hazard_ctrl_unit

Overview:
- Parametrised successor to the forwarding-only hazard unit of the 5-stage RV32 pipeline.
- Adds the following on top of operand forwarding:
  - load-use stall detection;
  - branch/jump flush;
  - a multi-cycle execute (MUL/DIV) stall sequencer;
  - optional hazard performance counters.
- Sits beside the pipeline stages. Drives the stall/flush inputs of the IF/ID, ID/EX and EX/MEM pipeline registers and the forwarding muxes in Execute.

Parameters:
- REG_AW, 5, register address width.
- MC_LAT, 4, execute-stage latency of a multi-cycle op in cycles (1..15; 1 = single-cycle, no stall).
- CNT_W, 16, performance counter width (only used with HAZARD_PERF_CNT_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- RS1_D, RS2_D  in  REG_AW  source registers of instruction in Decode.
- RS1_E, RS2_E  in  REG_AW  source registers in Execute.
- Rd_E  in  REG_AW  destination register in Execute.
- Load_E  in  1  instruction in Execute is a load (ResultSrc_E == 2'b01).
- MultiCyc_E  in  1  instruction in Execute is a multi-cycle op.
- PCSrc_E  in  1  branch taken / jump in Execute.
- RegWrite_M, RegWrite_W  in  1  write enables in Memory / Writeback.
- Rd_M, Rd_W  in  REG_AW  destinations in Memory / Writeback.
- ForwardAE, ForwardBE  out  2  operand select: 00 regfile, 10 from ALUResult_M, 01 from Result_W.
- Stall_F, Stall_D, Stall_E  out  1  hold PC / IF-ID / ID-EX registers.
- Flush_D, Flush_E, Flush_M  out  1  bubble IF-ID / ID-EX / EX-MEM registers.
- MC_Busy  out  1  multi-cycle sequencer active.
- MC_Done  out  1  one-cycle pulse: multi-cycle result valid in Execute this cycle.
- StallCnt, FlushCnt  out  CNT_W  performance counters (present only with HAZARD_PERF_CNT_EN).

Interface (already decided): one clock; reset is asynchronous and active-low. Port names are clk and rst, with rst == 0 meaning reset.

Behaviour:
- Reset (rst low, async):
  - all outputs 0;
  - FSM enters IDLE and the cycle counter is cleared;
  - reset mid-sequence aborts the multi-cycle op with no MC_Done pulse.
- Forwarding (combinational, computed separately for A and B):
  - M match (RegWrite_M, Rd_M != 0, Rd_M == RS*_E) -> 10;
  - else W match -> 01;
  - else 00;
  - M has priority over W;
  - register x0 is never forwarded.
- Load-use (combinational):
  - Condition: Load_E && Rd_E != 0 && (Rd_E == RS1_D || Rd_E == RS2_D).
  - Response: Stall_F = Stall_D = 1 and Flush_E = 1, for exactly one cycle per occurrence.
- Control flush: PCSrc_E -> Flush_D = Flush_E = 1.
  - If a load-use condition occurs in the same cycle, the flush wins: Stall_F/Stall_D are 0, because the Decode instruction is squashed.
- Multi-cycle FSM, states IDLE, BUSY, DONE:
  - IDLE -> BUSY when MultiCyc_E && MC_LAT > 1. Counter loads MC_LAT-2.
  - BUSY:
    - Stall_F = Stall_D = Stall_E = 1 and Flush_M = 1 (bubble into Memory);
    - MC_Busy = 1;
    - counter decrements each cycle; at 0 -> DONE.
  - DONE:
    - one cycle with no stall; MC_Done = 1;
    - the op advances to Memory -> IDLE.
  - The total number of stall cycles is exactly MC_LAT-1.
  - With MC_LAT == 1 the FSM stays in IDLE and MC_Done pulses in the same cycle MultiCyc_E is high.
  - The BUSY stall overrides load-use. Decode/Execute are frozen during BUSY, so no new load-use or PCSrc_E can be evaluated.
  - MultiCyc_E being high during DONE does not re-trigger the FSM. Re-entry needs MultiCyc_E high in IDLE, so back-to-back ops each take a full sequence.
- All stall/flush outputs are combinational from the inputs and FSM state. There is no extra latency.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined:
  - StallCnt increments every cycle in which Stall_D = 1.
  - FlushCnt increments every cycle in which Flush_D or Flush_E = 1.
  - Both are registered, saturate at 2^CNT_W-1 (no wrap), and are cleared by reset.
- When undefined:
  - the ports and counters are absent;
  - all other behaviour is identical.

Test Plan:
- Forwarding: RegWrite_M = 1, Rd_M = 5, RegWrite_W = 1, Rd_W = 5, RS1_E = 5 -> ForwardAE = 10. Then Rd_M = 0 -> ForwardAE = 01. Then RS2_E = 0 with Rd_W = 0 -> ForwardBE = 00.
- Load-use: Load_E = 1, Rd_E = 7, RS2_D = 7 -> Stall_F = Stall_D = Flush_E = 1 for exactly one cycle. With Rd_E = 0 -> no stall.
- Load-use plus PCSrc_E in the same cycle -> Flush_D = Flush_E = 1 and Stall_F = Stall_D = 0.
- Multi-cycle, MC_LAT = 4: MultiCyc_E pulse in IDLE ->
  - MC_Busy and Stall_F/D/E/Flush_M high for exactly 3 cycles;
  - then MC_Done high for 1 cycle;
  - then IDLE.
  - MC_LAT = 1 -> zero stall cycles and MC_Done in the same cycle.
- Reset mid-BUSY (rst low on the 2nd busy cycle) -> all outputs 0 immediately and no MC_Done. After release, a new op gets the full 3-cycle stall.
- With HAZARD_PERF_CNT_EN, CNT_W = 4: 20 consecutive load-use cycles -> StallCnt saturates at 15. FlushCnt counts each PCSrc_E cycle. Reset clears both to 0.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// Hazard control for the 5-stage RV32 pipeline: forwarding, load-use stall, control flush and MUL/DIV stall sequencing.
// Outputs are combinational from inputs and FSM state; HAZARD_PERF_CNT_EN adds saturating StallCnt/FlushCnt counters.
module hazard_ctrl_unit #(
    parameter int REG_AW = 5,
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] RS1_D,
    input  logic [REG_AW-1:0] RS2_D,
    input  logic [REG_AW-1:0] RS1_E,
    input  logic [REG_AW-1:0] RS2_E,
    input  logic [REG_AW-1:0] Rd_E,
    input  logic              Load_E,
    input  logic              MultiCyc_E,
    input  logic              PCSrc_E,
    input  logic              RegWrite_M,
    input  logic              RegWrite_W,
    input  logic [REG_AW-1:0] Rd_M,
    input  logic [REG_AW-1:0] Rd_W,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              Stall_F,
    output logic              Stall_D,
    output logic              Stall_E,
    output logic              Flush_D,
    output logic              Flush_E,
    output logic              Flush_M,
    output logic              MC_Busy,
    output logic              MC_Done
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [CNT_W-1:0]  FlushCnt
`endif
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mc_state_e;

    localparam int               CTR_W    = 4;
    localparam bit               MC_EN    = (MC_LAT > 1);
    localparam logic [CTR_W-1:0] CTR_LOAD = MC_EN ? CTR_W'(MC_LAT - 2) : '0;

    mc_state_e        state_q, state_d;
    logic [CTR_W-1:0] ctr_q, ctr_d;

    logic busy;
    logic load_use;

    // Memory stage wins over Writeback since it holds the younger result; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic              we_m,
        input logic [REG_AW-1:0] rd_m,
        input logic              we_w,
        input logic [REG_AW-1:0] rd_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (we_m && (rd_m != '0) && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (we_w && (rd_w != '0) && (rd_w == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        case (state_q)
            IDLE: begin
                if (MultiCyc_E && MC_EN) begin
                    state_d = BUSY;
                    ctr_d   = CTR_LOAD;
                end
            end
            BUSY: begin
                if (ctr_q == '0) begin
                    state_d = DONE;
                end else begin
                    ctr_d = ctr_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ctr_q   <= '0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
        end
    end

    // Everything is qualified by rst so the unit is quiet while reset is held.
    always_comb begin
        busy     = (state_q == BUSY);
        load_use = Load_E && (Rd_E != '0) && ((Rd_E == RS1_D) || (Rd_E == RS2_D));

        ForwardAE = rst ? fwd_sel(RS1_E, RegWrite_M, Rd_M, RegWrite_W, Rd_W) : 2'b00;
        ForwardBE = rst ? fwd_sel(RS2_E, RegWrite_M, Rd_M, RegWrite_W, Rd_W) : 2'b00;

        // A taken branch squashes Decode, so a coincident load-use needs no stall.
        Stall_F = rst && (busy || (load_use && !PCSrc_E));
        Stall_D = Stall_F;
        Stall_E = rst && busy;
        Flush_D = rst && !busy && PCSrc_E;
        Flush_E = rst && !busy && (PCSrc_E || load_use);
        Flush_M = rst && busy;
        MC_Busy = rst && busy;
        MC_Done = rst && (MC_EN ? (state_q == DONE) : MultiCyc_E);
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (Stall_D && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if ((Flush_D || Flush_E) && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: expected output vectors are queued per cycle and compared on the falling edge.
// A second instance with MC_LAT=1 runs on the same inputs to cover the no-stall multi-cycle case.
module tb_hazard_ctrl_unit;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [REG_AW-1:0] RS1_D, RS2_D, RS1_E, RS2_E, Rd_E, Rd_M, Rd_W;
    logic              Load_E, MultiCyc_E, PCSrc_E, RegWrite_M, RegWrite_W;
    logic [1:0]        ForwardAE, ForwardBE, fa1, fb1;
    logic              Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Flush_M, MC_Busy, MC_Done;
    logic              sf1, sd1, se1, fd1, fe1, fm1, mc1_busy, mc1_done;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0]  StallCnt, FlushCnt, sc1, fc1;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [13:0] exp_q[$];
    string       tag_q[$];
    logic [13:0] sb_e;
    string       sb_t;
    logic [13:0] obs_v;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.REG_AW(REG_AW), .MC_LAT(4), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst),
        .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E), .Rd_E(Rd_E),
        .Load_E(Load_E), .MultiCyc_E(MultiCyc_E), .PCSrc_E(PCSrc_E),
        .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W), .Rd_M(Rd_M), .Rd_W(Rd_W),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E),
        .Flush_D(Flush_D), .Flush_E(Flush_E), .Flush_M(Flush_M),
        .MC_Busy(MC_Busy), .MC_Done(MC_Done)
`ifdef HAZARD_PERF_CNT_EN
        , .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
    );

    hazard_ctrl_unit #(.REG_AW(REG_AW), .MC_LAT(1), .CNT_W(CNT_W)) u_dut1 (
        .clk(clk), .rst(rst),
        .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E), .Rd_E(Rd_E),
        .Load_E(Load_E), .MultiCyc_E(MultiCyc_E), .PCSrc_E(PCSrc_E),
        .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W), .Rd_M(Rd_M), .Rd_W(Rd_W),
        .ForwardAE(fa1), .ForwardBE(fb1),
        .Stall_F(sf1), .Stall_D(sd1), .Stall_E(se1),
        .Flush_D(fd1), .Flush_E(fe1), .Flush_M(fm1),
        .MC_Busy(mc1_busy), .MC_Done(mc1_done)
`ifdef HAZARD_PERF_CNT_EN
        , .StallCnt(sc1), .FlushCnt(fc1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bit order: fa[1:0] fb[1:0] sf sd se fd fe fm busy done | mc1 stall_e/busy, mc1 done
    function automatic logic [13:0] ev(input logic [1:0] fa, input logic [1:0] fb,
                                       input logic sf, input logic sd, input logic se,
                                       input logic fd, input logic fe, input logic fm,
                                       input logic bz, input logic dn, input logic d1);
        return {fa, fb, sf, sd, se, fd, fe, fm, bz, dn, 1'b0, d1};
    endfunction

    function automatic logic [13:0] busy_v(input logic d1);
        return ev(2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, d1);
    endfunction

    function automatic logic [13:0] done_v(input logic d1);
        return ev(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, d1);
    endfunction

    function automatic logic [13:0] zero_v(input logic d1);
        return ev(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, d1);
    endfunction

    task automatic clr_in();
        RS1_D = '0; RS2_D = '0; RS1_E = '0; RS2_E = '0; Rd_E = '0; Rd_M = '0; Rd_W = '0;
        Load_E = 1'b0; MultiCyc_E = 1'b0; PCSrc_E = 1'b0; RegWrite_M = 1'b0; RegWrite_W = 1'b0;
    endtask

    // Queue the expectation for the inputs currently driven, then advance one cycle.
    task automatic step(input string tag, input logic [13:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    always_comb begin
        obs_v = {ForwardAE, ForwardBE, Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Flush_M,
                 MC_Busy, MC_Done, (mc1_busy | se1), mc1_done};
    end

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            sb_e = exp_q.pop_front();
            sb_t = tag_q.pop_front();
            check(sb_t, 32'(obs_v), 32'(sb_e));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_in();
        rst = 1'b0;
        Load_E = 1'b1; Rd_E = 5'd7; RS2_D = 5'd7; PCSrc_E = 1'b1; MultiCyc_E = 1'b1;
        RegWrite_M = 1'b1; Rd_M = 5'd5; RS1_E = 5'd5;
        @(posedge clk);
        #1;
        step("reset_outputs", zero_v(1'b0));
        rst = 1'b1;
        clr_in();
        step("idle", zero_v(1'b0));

        // Forwarding
        RegWrite_M = 1'b1; Rd_M = 5'd5; RegWrite_W = 1'b1; Rd_W = 5'd5; RS1_E = 5'd5;
        step("fwd_m_prio", ev(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        Rd_M = 5'd0;
        step("fwd_w", ev(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        RS2_E = 5'd5;
        step("fwd_b_w", ev(2'b01, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        RS2_E = 5'd0; Rd_W = 5'd0;
        step("fwd_x0", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        RegWrite_M = 1'b0; Rd_M = 5'd9; RS2_E = 5'd9; RS1_E = 5'd9;
        step("fwd_no_we", zero_v(1'b0));
        RegWrite_M = 1'b1; RS1_E = 5'd3;
        step("fwd_b_m", ev(2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        clr_in();

        // Load-use and control flush
        Load_E = 1'b1; Rd_E = 5'd7; RS2_D = 5'd7;
        step("lu_rs2", ev(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0, 0, 0));
        Load_E = 1'b0;
        step("lu_one_cycle", zero_v(1'b0));
        Load_E = 1'b1; RS2_D = 5'd0; RS1_D = 5'd7;
        step("lu_rs1", ev(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0, 0, 0));
        Rd_E = 5'd0; RS1_D = 5'd0;
        step("lu_x0", zero_v(1'b0));
        Rd_E = 5'd7; RS2_D = 5'd7; PCSrc_E = 1'b1;
        step("lu_and_flush", ev(2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        Load_E = 1'b0;
        step("flush_only", ev(2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        clr_in();

        // Single multi-cycle op, with hazards presented during BUSY
        MultiCyc_E = 1'b1;
        step("mc_start", zero_v(1'b1));
        MultiCyc_E = 1'b0;
        step("mc_busy1", busy_v(1'b0));
        Load_E = 1'b1; Rd_E = 5'd7; RS2_D = 5'd7; PCSrc_E = 1'b1;
        step("mc_busy2_override", busy_v(1'b0));
        clr_in();
        step("mc_busy3", busy_v(1'b0));
        step("mc_done", done_v(1'b0));
        step("mc_idle", zero_v(1'b0));

        // MultiCyc_E held high: DONE must not re-trigger, IDLE does
        MultiCyc_E = 1'b1;
        step("hold_start", zero_v(1'b1));
        for (int i = 0; i < 3; i++) step("hold_busy", busy_v(1'b1));
        step("hold_done_no_retrig", done_v(1'b1));
        step("hold_restart", zero_v(1'b1));
        MultiCyc_E = 1'b0;
        step("re_busy1", busy_v(1'b0));

        // Reset on the second BUSY cycle aborts silently
        rst = 1'b0;
        step("rst_mid_busy", zero_v(1'b0));
        step("rst_held", zero_v(1'b0));
        rst = 1'b1;
        step("rst_release", zero_v(1'b0));
        step("rst_no_done", zero_v(1'b0));
        MultiCyc_E = 1'b1;
        step("post_rst_start", zero_v(1'b1));
        MultiCyc_E = 1'b0;
        for (int i = 0; i < 3; i++) step("post_rst_busy", busy_v(1'b0));
        step("post_rst_done", done_v(1'b0));
        step("post_rst_idle", zero_v(1'b0));

`ifdef HAZARD_PERF_CNT_EN
        rst = 1'b0;
        step("cnt_rst", zero_v(1'b0));
        rst = 1'b1;
        check("stallcnt_rst", 32'(StallCnt), 32'd0);
        check("flushcnt_rst", 32'(FlushCnt), 32'd0);
        PCSrc_E = 1'b1;
        for (int i = 0; i < 3; i++) step("cnt_flush", ev(2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        PCSrc_E = 1'b0;
        check("flushcnt_3", 32'(FlushCnt), 32'd3);
        check("stallcnt_0", 32'(StallCnt), 32'd0);
        Load_E = 1'b1; Rd_E = 5'd7; RS2_D = 5'd7;
        for (int i = 0; i < 20; i++) step("cnt_lu", ev(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0, 0, 0));
        clr_in();
        check("stallcnt_sat", 32'(StallCnt), 32'd15);
        check("flushcnt_sat", 32'(FlushCnt), 32'd15);
        rst = 1'b0;
        #1;
        check("stallcnt_clr", 32'(StallCnt), 32'd0);
        check("flushcnt_clr", 32'(FlushCnt), 32'd0);
        step("cnt_rst2", zero_v(1'b0));
        rst = 1'b1;
`endif

        @(negedge clk);
        #1;
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
